// File: rtl/branch_redirect_ctrl.sv
// ============================================================================
// branch_redirect_ctrl
// ----------------------------------------------------------------------------
// Front-end sequencer for branches and jumps that resolve in EX. The front end
// statically predicts not-taken. A taken resolution with a word-aligned target
// does three things:
//   - issues a registered redirect to fetch over a valid/ready handshake
//   - flushes the IF/ID and ID/EX registers
//   - ignores further EX resolutions until the wrong path has drained
// A taken resolution with a misaligned target raises a one-cycle exception
// pulse and does nothing else.
//
// Parameters:
//   FLUSH_CYCLES  cycles the flushes stay high after the redirect handshake
//                 (0 allowed)
//   CNT_W         performance counter width
//
// Optional build macro:
//   BRANCH_REDIRECT_PERF_CNT_EN  builds the branch and taken counters. When it
//                                is undefined the counter ports are tied to 0.
//
// Ports:
//   i_Clk_1            clock, rising edge
//   i_Rst_n_1          synchronous active-low reset
//   i_ExValid_1        EX holds a valid branch/jump
//   i_IsCond_1         EX instruction is a conditional branch (0 = JAL/JALR)
//   i_Jump_1           resolved taken
//   i_Target_32        resolved target PC
//   i_RedirectReady_1  fetch accepts the redirect
//   o_RedirectValid_1  redirect request to fetch
//   o_RedirectPc_32    redirect target PC (holds its last value)
//   o_FlushIfId_1      flush IF/ID
//   o_FlushIdEx_1      flush ID/EX
//   o_Busy_1           not IDLE; EX resolutions are ignored
//   o_MisalignExc_1    one-cycle pulse for a taken, misaligned target
//   o_MisalignTval_32  offending target, valid with o_MisalignExc_1
//   o_BranchCnt_32     conditional branches resolved
//   o_TakenCnt_32      taken, aligned resolutions accepted
// ============================================================================
module branch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              i_Clk_1,
    input  logic              i_Rst_n_1,
    input  logic              i_ExValid_1,
    input  logic              i_IsCond_1,
    input  logic              i_Jump_1,
    input  logic [31:0]       i_Target_32,
    input  logic              i_RedirectReady_1,
    output logic              o_RedirectValid_1,
    output logic [31:0]       o_RedirectPc_32,
    output logic              o_FlushIfId_1,
    output logic              o_FlushIdEx_1,
    output logic              o_Busy_1,
    output logic              o_MisalignExc_1,
    output logic [31:0]       o_MisalignTval_32,
    output logic [CNT_W-1:0]  o_BranchCnt_32,
    output logic [CNT_W-1:0]  o_TakenCnt_32
);

    // The counter must hold FLUSH_CYCLES; keep it at least one bit wide so the
    // FLUSH_CYCLES == 0 build still elaborates.
    localparam int FC_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } stateT;

    stateT           stateQ, stateNxt;
    logic [FC_W-1:0] flushCntQ, flushCntNxt;

    // Resolutions are only looked at in IDLE. In REDIRECT and FLUSH, EX holds
    // wrong-path instructions.
    logic accept, acceptTaken, acceptMisalign;

    assign accept         = (stateQ == IDLE) && i_ExValid_1;
    assign acceptTaken    = accept && i_Jump_1 && (i_Target_32[1:0] == 2'b00);
    assign acceptMisalign = accept && i_Jump_1 && (i_Target_32[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk_1) begin
        if (!i_Rst_n_1) begin
            stateQ    <= IDLE;
            flushCntQ <= '0;
        end else begin
            stateQ    <= stateNxt;
            flushCntQ <= flushCntNxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        stateNxt    = stateQ;
        flushCntNxt = flushCntQ;
        unique case (stateQ)
            IDLE: begin
                if (acceptTaken) stateNxt = REDIRECT;
            end
            REDIRECT: begin
                if (i_RedirectReady_1) begin
                    if (FLUSH_CYCLES > 0) begin
                        stateNxt    = FLUSH;
                        flushCntNxt = FC_W'(FLUSH_CYCLES);
                    end else begin
                        stateNxt = IDLE;
                    end
                end
            end
            FLUSH: begin
                flushCntNxt = flushCntQ - FC_W'(1);
                // With a count of 1, this is the last flush cycle.
                if (flushCntQ == FC_W'(1)) stateNxt = IDLE;
            end
            default: begin
                stateNxt    = IDLE;
                flushCntNxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. Outputs are decoded from the next state and then
    // registered, so each one lines up with the state it describes and has
    // no combinational path from the inputs.
    // ------------------------------------------------------------------
    logic        validNxt, flushNxt, busyNxt, excNxt;
    logic [31:0] pcNxt, tvalNxt;

    always_comb begin
        validNxt = (stateNxt == REDIRECT);
        flushNxt = (stateNxt != IDLE);
        busyNxt  = (stateNxt != IDLE);
        excNxt   = acceptMisalign;
        pcNxt    = acceptTaken    ? i_Target_32 : o_RedirectPc_32;
        tvalNxt  = acceptMisalign ? i_Target_32 : o_MisalignTval_32;
    end

    always_ff @(posedge i_Clk_1) begin
        if (!i_Rst_n_1) begin
            o_RedirectValid_1 <= 1'b0;
            o_RedirectPc_32   <= '0;
            o_FlushIfId_1     <= 1'b0;
            o_FlushIdEx_1     <= 1'b0;
            o_Busy_1          <= 1'b0;
            o_MisalignExc_1   <= 1'b0;
            o_MisalignTval_32 <= '0;
        end else begin
            o_RedirectValid_1 <= validNxt;
            o_RedirectPc_32   <= pcNxt;
            o_FlushIfId_1     <= flushNxt;
            o_FlushIdEx_1     <= flushNxt;
            o_Busy_1          <= busyNxt;
            o_MisalignExc_1   <= excNxt;
            o_MisalignTval_32 <= tvalNxt;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (wrap modulo 2^CNT_W)
    // ------------------------------------------------------------------
`ifdef BRANCH_REDIRECT_PERF_CNT_EN
    logic [CNT_W-1:0] branchCntQ, takenCntQ;

    always_ff @(posedge i_Clk_1) begin
        if (!i_Rst_n_1) begin
            branchCntQ <= '0;
            takenCntQ  <= '0;
        end else begin
            if (accept && i_IsCond_1) branchCntQ <= branchCntQ + CNT_W'(1);
            if (acceptTaken)          takenCntQ  <= takenCntQ + CNT_W'(1);
        end
    end

    assign o_BranchCnt_32 = branchCntQ;
    assign o_TakenCnt_32  = takenCntQ;
`else
    // The conditional flag only feeds the branch counter.
    logic unusedIsCond;
    assign unusedIsCond   = i_IsCond_1;
    assign o_BranchCnt_32 = '0;
    assign o_TakenCnt_32  = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ============================================================================
// tb_branch_redirect_ctrl
// Directed-vector bench for branch_redirect_ctrl (FLUSH_CYCLES=2, CNT_W=4).
// Counter expectations depend on BRANCH_REDIRECT_PERF_CNT_EN: with the macro
// defined they follow the hand-computed counts, otherwise they must read 0.
// ============================================================================
module tb_branch_redirect_ctrl;

    localparam int CNT_W = 4;
`ifdef BRANCH_REDIRECT_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstN;
    logic             exValid, isCond, jump, ready;
    logic [31:0]      target;
    logic             redirValid, flushIfId, flushIdEx, busy, misExc;
    logic [31:0]      redirPc, misTval;
    logic [CNT_W-1:0] branchCnt, takenCnt;

    int chkCnt = 0;
    int errCnt = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .i_Clk_1           (clk),
        .i_Rst_n_1         (rstN),
        .i_ExValid_1       (exValid),
        .i_IsCond_1        (isCond),
        .i_Jump_1          (jump),
        .i_Target_32       (target),
        .i_RedirectReady_1 (ready),
        .o_RedirectValid_1 (redirValid),
        .o_RedirectPc_32   (redirPc),
        .o_FlushIfId_1     (flushIfId),
        .o_FlushIdEx_1     (flushIdEx),
        .o_Busy_1          (busy),
        .o_MisalignExc_1   (misExc),
        .o_MisalignTval_32 (misTval),
        .o_BranchCnt_32    (branchCnt),
        .o_TakenCnt_32     (takenCnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the redirect, flush and busy outputs together.
    task automatic chkFront(input string tag, input logic v, input logic [31:0] pc,
                            input logic fl, input logic b);
        chk({tag, ".valid"}, {31'd0, redirValid}, {31'd0, v});
        chk({tag, ".pc"},    redirPc, pc);
        chk({tag, ".fIfId"}, {31'd0, flushIfId}, {31'd0, fl});
        chk({tag, ".fIdEx"}, {31'd0, flushIdEx}, {31'd0, fl});
        chk({tag, ".busy"},  {31'd0, busy}, {31'd0, b});
    endtask

    // Counter values are only expected when the counters are built.
    task automatic chkCnts(input string tag, input int br, input int tk);
        chk({tag, ".brCnt"}, 32'(branchCnt), PERF ? 32'(br % 16) : 32'd0);
        chk({tag, ".tkCnt"}, 32'(takenCnt),  PERF ? 32'(tk % 16) : 32'd0);
    endtask

    initial begin
        rstN = 1'b0; exValid = 1'b0; isCond = 1'b0; jump = 1'b0;
        ready = 1'b0; target = 32'h0;
        tick(); tick();

        // ---------------- reset state ----------------
        chkFront("rst", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst.exc",  {31'd0, misExc}, 32'd0);
        chk("rst.tval", misTval, 32'h0);
        chkCnts("rst", 0, 0);
        rstN = 1'b1;
        tick();

        // ---------------- not-taken conditional ----------------
        exValid = 1'b1; isCond = 1'b1; jump = 1'b0; target = 32'h40;
        tick();
        exValid = 1'b0;
        chkFront("nt", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("nt.exc", {31'd0, misExc}, 32'd0);
        chkCnts("nt", 1, 0);

        // ---------------- JAL 0x100, ready immediately ----------------
        exValid = 1'b1; isCond = 1'b0; jump = 1'b1; target = 32'h100; ready = 1'b1;
        tick();                                         // edge T
        exValid = 1'b0;
        chkFront("jal.t1", 1'b1, 32'h100, 1'b1, 1'b1);
        tick();                                         // handshake edge
        chkFront("jal.t2", 1'b0, 32'h100, 1'b1, 1'b1);
        tick();
        chkFront("jal.t3", 1'b0, 32'h100, 1'b1, 1'b1);
        tick();
        chkFront("jal.t4", 1'b0, 32'h100, 1'b0, 1'b0);
        chkCnts("jal", 1, 1);

        // ---------------- branch 0x200, ready low 3 cycles ----------------
        ready = 1'b0;
        exValid = 1'b1; isCond = 1'b1; jump = 1'b1; target = 32'h200;
        tick();
        // Wrong-path resolutions (misaligned, to also prove no exception)
        exValid = 1'b1; jump = 1'b1; target = 32'h302;
        for (int i = 0; i < 3; i++) begin
            chkFront($sformatf("hold%0d", i), 1'b1, 32'h200, 1'b1, 1'b1);
            chk($sformatf("hold%0d.exc", i), {31'd0, misExc}, 32'd0);
            if (i < 2) tick();
        end
        ready = 1'b1;
        tick();                                         // handshake edge
        ready = 1'b0;
        chkFront("br.fl1", 1'b0, 32'h200, 1'b1, 1'b1);
        chk("br.fl1.exc", {31'd0, misExc}, 32'd0);
        target = 32'h300;                               // aligned wrong-path jump
        tick();
        chkFront("br.fl2", 1'b0, 32'h200, 1'b1, 1'b1);
        tick();                                         // FLUSH->IDLE edge, sample ignored
        chkFront("br.idle", 1'b0, 32'h200, 1'b0, 1'b0);
        exValid = 1'b0;
        tick();
        chkFront("br.idle2", 1'b0, 32'h200, 1'b0, 1'b0);
        chkCnts("br", 2, 2);

        // ---------------- misaligned target 0x102 ----------------
        exValid = 1'b1; isCond = 1'b1; jump = 1'b1; target = 32'h102;
        tick();
        exValid = 1'b0;
        chk("mis.exc",  {31'd0, misExc}, 32'd1);
        chk("mis.tval", misTval, 32'h102);
        chkFront("mis", 1'b0, 32'h200, 1'b0, 1'b0);
        tick();
        chk("mis.exc2",  {31'd0, misExc}, 32'd0);
        chk("mis.busy2", {31'd0, busy}, 32'd0);
        chkCnts("mis", 3, 2);

        // ---------------- reset in the middle of FLUSH ----------------
        exValid = 1'b1; isCond = 1'b0; jump = 1'b1; target = 32'h400; ready = 1'b1;
        tick();                                         // REDIRECT
        exValid = 1'b0;
        tick();                                         // FLUSH
        chk("prerst.flush", {31'd0, flushIfId}, 32'd1);
        rstN = 1'b0;
        tick();
        chkFront("midrst", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("midrst.exc", {31'd0, misExc}, 32'd0);
        chkCnts("midrst", 0, 0);
        rstN = 1'b1;
        exValid = 1'b1; isCond = 1'b0; jump = 1'b1; target = 32'h500; ready = 1'b1;
        tick();
        exValid = 1'b0;
        chkFront("postrst", 1'b1, 32'h500, 1'b1, 1'b1);
        tick(); tick(); tick();
        chkFront("postrst.done", 1'b0, 32'h500, 1'b0, 1'b0);
        chkCnts("postrst", 0, 1);

        // ---------------- 16 taken conditional branches: counters wrap -------
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exValid = 1'b1; isCond = 1'b1; jump = 1'b1; target = 32'h1000 + 32'(i * 4);
            tick();
            exValid = 1'b0;
            tick(); tick(); tick();
            if (i == 14) chkCnts("wrap15", 15, 15);
        end
        chkFront("wrap", 1'b0, 32'h103c, 1'b0, 1'b0);
        chkCnts("wrap", 16, 16);

        $display("Simulation finished: %0d checks, %0d errors", chkCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the front end after a branch or jump resolves in EX, using the taken/not-taken decision from the jump/branch comparator.
- Statically predicts not-taken. A taken resolution causes a registered PC redirect to fetch over a valid/ready handshake, flushes the IF/ID and ID/EX registers, and blocks further resolutions until the wrong path has drained.
- Sits between the EX stage, the fetch unit and the pipeline register flush inputs.

Parameters:
- FLUSH_CYCLES, 2, cycles flush stays asserted after the redirect handshake completes (0 allowed).
- CNT_W, 32, width of the performance counters (Optional Feature only).

Ports:
- i_Clk_1  in  1  clock, rising edge.
- i_Rst_n_1  in  1  synchronous, active-low reset.
- i_ExValid_1  in  1  EX holds a valid branch/jump this cycle.
- i_IsCond_1  in  1  EX instruction is a conditional branch (0 = JAL/JALR).
- i_Jump_1  in  1  resolved taken, from the jump/branch comparator.
- i_Target_32  in  32  resolved target PC.
- i_RedirectReady_1  in  1  fetch accepts the redirect this cycle.
- o_RedirectValid_1  out  1  redirect request to fetch.
- o_RedirectPc_32  out  32  redirect target PC.
- o_FlushIfId_1  out  1  flush IF/ID register.
- o_FlushIdEx_1  out  1  flush ID/EX register.
- o_Busy_1  out  1  state is not IDLE; EX resolutions are ignored.
- o_MisalignExc_1  out  1  one-cycle pulse: taken target not word-aligned.
- o_MisalignTval_32  out  32  offending target, valid with o_MisalignExc_1.
- o_BranchCnt_32  out  CNT_W  conditional branches resolved (Optional Feature).
- o_TakenCnt_32  out  CNT_W  taken branches/jumps accepted (Optional Feature).

Behaviour:
- All outputs are registered.
- Reset:
  - Synchronous, active-low, applied at any time including mid-REDIRECT or mid-FLUSH.
  - Next state is IDLE; flush counter is 0.
  - All outputs are 0; counters are 0.
- States: IDLE, REDIRECT, FLUSH.
- IDLE:
  - Accept condition: i_ExValid_1=1 at edge T.
  - Not taken (i_Jump_1=0): no action, stay in IDLE.
  - Taken and i_Target_32[1:0]==0: at T+1 enter REDIRECT with o_RedirectValid_1=1, o_RedirectPc_32=target, both flushes=1.
  - Taken and i_Target_32[1:0]!=0: at T+1 o_MisalignExc_1=1 for exactly one cycle and o_MisalignTval_32=target. No redirect, no flush, stay in IDLE.
- REDIRECT:
  - o_RedirectValid_1, o_RedirectPc_32 and both flushes are held stable until i_RedirectReady_1=1 is sampled.
  - On that handshake edge:
    - FLUSH_CYCLES>0: enter FLUSH, counter=FLUSH_CYCLES, o_RedirectValid_1 deasserts at the next cycle.
    - FLUSH_CYCLES==0: return to IDLE with all outputs deasserted.
  - If ready is already high in the first REDIRECT cycle, the handshake completes in that cycle (one-cycle redirect).
- FLUSH:
  - Both flushes asserted, o_RedirectValid_1=0.
  - Counter decrements each cycle; at counter==1 the next state is IDLE.
  - Flushes are high for exactly FLUSH_CYCLES cycles after the handshake cycle.
- o_Busy_1 = (state != IDLE). In REDIRECT and FLUSH, i_ExValid_1 is ignored (wrong-path instruction): no redirect, no exception, no counting.
- The IDLE-to-REDIRECT transition is the only path that changes o_RedirectPc_32; it holds its last value otherwise.
- Back-to-back: a resolution sampled on the cycle FLUSH returns to IDLE is still ignored. The first eligible sample is the first cycle o_Busy_1=0.

Optional Feature:
- Macro: BRANCH_REDIRECT_PERF_CNT_EN.
- Defined:
  - o_BranchCnt_32 increments on every accepted IDLE resolution with i_IsCond_1=1.
  - o_TakenCnt_32 increments on every accepted taken resolution with an aligned target.
  - Both wrap modulo 2^CNT_W; reset to 0.
- Undefined: both ports are tied to 0 and no counter registers are built. All other behaviour is identical.

Test Plan:
- Not-taken conditional in IDLE (ExValid=1, IsCond=1, Jump=0) -> no redirect or flush, Busy stays 0; with macro, BranchCnt=1 and TakenCnt=0.
- Taken JAL to 0x0000_0100 at T, ready=1 at T+1 -> RedirectValid=1 and Pc=0x100 only at T+1; flushes high T+1..T+3 (FLUSH_CYCLES=2); Busy back to 0 at T+4.
- Taken branch to 0x200 with ready low for 3 cycles -> Valid/Pc/flushes held stable 3 cycles; handshake on 4th; second ExValid injected during REDIRECT and FLUSH is ignored (Pc stays 0x200).
- Taken target 0x0000_0102 -> MisalignExc pulse of one cycle at T+1, Tval=0x102, no redirect or flush, Busy=0.
- Reset (i_Rst_n_1=0) asserted in the middle of FLUSH -> next edge IDLE, all outputs 0; an aligned taken jump the cycle after reset deasserts is accepted normally.
- With macro and CNT_W=4, 16 taken conditional branches -> both counters wrap to 0.
